// File: rtl/sd_block_responder_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : sd_block_responder_pkg
//  Brief    : Shared block geometry constants and transfer state encoding
//  Revision : 1.0 - initial release
// ============================================================================
package sd_block_responder_pkg;

  localparam int BLK_BYTES = 512;
  localparam int BLK_SHIFT = 9;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PH_A = 2'd1,
    PH_B = 2'd2,
    DONE = 2'd3
  } state_t;

endpackage
`default_nettype wire

// File: rtl/sd_block_responder_if.sv
`default_nettype none
// ============================================================================
//  Module   : sd_block_responder_if
//  Brief    : Core-side block buffer handshake and backing-memory port bundle
//  Revision : 1.0 - initial release
// ============================================================================
interface sd_block_responder_if
  import sd_block_responder_pkg::*;
#(
  parameter int VDNUM  = 3,
  parameter int ADDR_W = 24
);

  logic [31:0]          sd_lba      [VDNUM];
  logic [VDNUM-1:0]     sd_rd;
  logic [VDNUM-1:0]     sd_wr;
  logic [VDNUM-1:0]     sd_ack;
  logic [BLK_SHIFT-1:0] sd_buff_addr;
  logic [7:0]           sd_buff_dout;
  logic                 sd_buff_wr;
  logic [7:0]           sd_buff_din [VDNUM];
  logic [VDNUM-1:0]     drive_ro;
  logic [ADDR_W-1:0]    mem_addr;
  logic                 mem_rd;
  logic [7:0]           mem_dout;
  logic                 mem_wr;
  logic [7:0]           mem_din;
  logic                 busy;

  // Responder side
  modport master (
    input  sd_lba, sd_rd, sd_wr, sd_buff_din, drive_ro, mem_dout,
    output sd_ack, sd_buff_addr, sd_buff_dout, sd_buff_wr,
           mem_addr, mem_rd, mem_wr, mem_din, busy
  );

  // Core / memory side
  modport slave (
    output sd_lba, sd_rd, sd_wr, sd_buff_din, drive_ro, mem_dout,
    input  sd_ack, sd_buff_addr, sd_buff_dout, sd_buff_wr,
           mem_addr, mem_rd, mem_wr, mem_din, busy
  );

endinterface
`default_nettype wire

// File: rtl/sd_req_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : sd_req_arbiter
//  Brief    : Fixed-priority drive select; lowest index wins, read beats write
//  Revision : 1.0 - initial release
// ============================================================================
module sd_req_arbiter #(
  parameter int VDNUM = 3,
  parameter int DRV_W = 2
) (
  input  wire logic [VDNUM-1:0] i_rd,
  input  wire logic [VDNUM-1:0] i_wr,
  output logic                  o_req,
  output logic [DRV_W-1:0]      o_drive,
  output logic                  o_is_rd
);

  // Scan from the top so the lowest requesting index is the last one written
  always_comb begin
    o_req   = 1'b0;
    o_drive = '0;
    o_is_rd = 1'b0;
    for (int i = VDNUM - 1; i >= 0; i--) begin
      if (i_rd[i] || i_wr[i]) begin
        o_req   = 1'b1;
        o_drive = DRV_W'(i);
        o_is_rd = i_rd[i];
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/sd_block_responder.sv
`default_nettype none
// ============================================================================
//  Module   : sd_block_responder
//  Brief    : Serves 512-byte block reads/writes for several virtual drives
//             from a byte-wide backing memory, two cycles per byte
//  Revision : 1.0 - initial release
// ============================================================================
module sd_block_responder
  import sd_block_responder_pkg::*;
#(
  parameter int VDNUM  = 3,
  parameter int ADDR_W = 24
) (
  input wire logic              clk_sys,
  input wire logic              reset,
  sd_block_responder_if.master  bus
);

  localparam int DRV_W = (VDNUM > 1) ? $clog2(VDNUM) : 1;
  localparam int LBA_W = ADDR_W - BLK_SHIFT;

  state_t               r_state, w_state_nxt;
  logic [DRV_W-1:0]     r_drive, w_drive;
  logic                 r_is_rd, w_is_rd;
  logic [LBA_W-1:0]     r_lba, w_lba;
  logic                 r_ro, w_ro;
  logic                 r_oor, w_oor;
  logic [BLK_SHIFT-1:0] r_cnt, w_cnt;
  logic [VDNUM-1:0]     r_ack, w_ack;
  logic [BLK_SHIFT-1:0] r_buff_addr, w_buff_addr;
  logic [7:0]           r_buff_dout, w_buff_dout;
  logic                 r_buff_wr, w_buff_wr;
  logic [ADDR_W-1:0]    r_mem_addr, w_mem_addr;
  logic                 r_mem_rd, w_mem_rd;
  logic                 r_mem_wr, w_mem_wr;
  logic [7:0]           r_mem_din, w_mem_din;
  logic                 r_busy, w_busy;

  logic                 w_req, w_req_rd;
  logic [DRV_W-1:0]     w_req_drive;
  logic [31:0]          w_lba_in;
  logic                 w_oor_in;
  logic [BLK_SHIFT-1:0] w_cnt_inc;

  sd_req_arbiter #(
    .VDNUM (VDNUM),
    .DRV_W (DRV_W)
  ) u_arb (
    .i_rd    (bus.sd_rd),
    .i_wr    (bus.sd_wr),
    .o_req   (w_req),
    .o_drive (w_req_drive),
    .o_is_rd (w_req_rd)
  );

  assign w_lba_in  = bus.sd_lba[w_req_drive];
  // Blocks past the end of the backing store are served but never touch memory
  assign w_oor_in  = (w_lba_in >> LBA_W) != 32'd0;
  assign w_cnt_inc = r_cnt + 1'b1;

  // Next state and next values of every registered output
  always_comb begin
    w_state_nxt = r_state;
    w_drive     = r_drive;
    w_is_rd     = r_is_rd;
    w_lba       = r_lba;
    w_ro        = r_ro;
    w_oor       = r_oor;
    w_cnt       = r_cnt;
    w_ack       = r_ack;
    w_buff_addr = r_buff_addr;
    w_buff_dout = r_buff_dout;
    w_buff_wr   = 1'b0;
    w_mem_addr  = r_mem_addr;
    w_mem_rd    = 1'b0;
    w_mem_wr    = 1'b0;
    w_mem_din   = r_mem_din;

    case (r_state)
      IDLE: begin
        if (w_req) begin
          w_state_nxt        = PH_A;
          w_drive            = w_req_drive;
          w_is_rd            = w_req_rd;
          w_lba              = w_lba_in[LBA_W-1:0];
          w_ro               = bus.drive_ro[w_req_drive];
          w_oor              = w_oor_in;
          w_cnt              = '0;
          w_ack              = '0;
          w_ack[w_req_drive] = 1'b1;
          // Byte 0 phase-A actions are launched with the acceptance edge
          if (w_req_rd) begin
            w_mem_addr = {w_lba_in[LBA_W-1:0], {BLK_SHIFT{1'b0}}};
            w_mem_rd   = !w_oor_in;
          end else begin
            w_buff_addr = '0;
          end
        end
      end
      PH_A: begin
        w_state_nxt = PH_B;
      end
      PH_B: begin
        // Finish byte r_cnt: memory data or core buffer data is valid now
        if (r_is_rd) begin
          w_buff_addr = r_cnt;
          w_buff_dout = r_oor ? 8'h00 : bus.mem_dout;
          w_buff_wr   = 1'b1;
        end else begin
          w_mem_addr = {r_lba, r_cnt};
          w_mem_din  = bus.sd_buff_din[r_drive];
          w_mem_wr   = !r_ro && !r_oor;
        end
        if (r_cnt == BLK_SHIFT'(BLK_BYTES - 1)) begin
          w_state_nxt = DONE;
        end else begin
          // Launch phase A of the following byte on the same edge
          w_state_nxt = PH_A;
          w_cnt       = w_cnt_inc;
          if (r_is_rd) begin
            w_mem_addr = {r_lba, w_cnt_inc};
            w_mem_rd   = !r_oor;
          end else begin
            w_buff_addr = w_cnt_inc;
          end
        end
      end
      DONE: begin
        w_state_nxt = IDLE;
        w_ack       = '0;
      end
      default: begin
        w_state_nxt = IDLE;
        w_ack       = '0;
      end
    endcase

    w_busy = (w_state_nxt != IDLE);
  end

  // State register
  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Transfer context and registered outputs
  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      r_drive     <= '0;
      r_is_rd     <= 1'b0;
      r_lba       <= '0;
      r_ro        <= 1'b0;
      r_oor       <= 1'b0;
      r_cnt       <= '0;
      r_ack       <= '0;
      r_buff_addr <= '0;
      r_buff_dout <= '0;
      r_buff_wr   <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_rd    <= 1'b0;
      r_mem_wr    <= 1'b0;
      r_mem_din   <= '0;
      r_busy      <= 1'b0;
    end else begin
      r_drive     <= w_drive;
      r_is_rd     <= w_is_rd;
      r_lba       <= w_lba;
      r_ro        <= w_ro;
      r_oor       <= w_oor;
      r_cnt       <= w_cnt;
      r_ack       <= w_ack;
      r_buff_addr <= w_buff_addr;
      r_buff_dout <= w_buff_dout;
      r_buff_wr   <= w_buff_wr;
      r_mem_addr  <= w_mem_addr;
      r_mem_rd    <= w_mem_rd;
      r_mem_wr    <= w_mem_wr;
      r_mem_din   <= w_mem_din;
      r_busy      <= w_busy;
    end
  end

  assign bus.sd_ack       = r_ack;
  assign bus.sd_buff_addr = r_buff_addr;
  assign bus.sd_buff_dout = r_buff_dout;
  assign bus.sd_buff_wr   = r_buff_wr;
  assign bus.mem_addr     = r_mem_addr;
  assign bus.mem_rd       = r_mem_rd;
  assign bus.mem_wr       = r_mem_wr;
  assign bus.mem_din      = r_mem_din;
  assign bus.busy         = r_busy;

endmodule
`default_nettype wire

// File: tb/tb_sd_block_responder.sv
`default_nettype none
// ============================================================================
//  Module   : tb_sd_block_responder
//  Brief    : Directed self-checking bench for sd_block_responder
//  Revision : 1.0 - initial release
// ============================================================================
module tb_sd_block_responder;

  logic clk = 1'b0;
  logic rst;
  logic mem_init;

  always #5 clk = ~clk;

  sd_block_responder_if #(.VDNUM(3), .ADDR_W(24)) bus ();

  sd_block_responder #(.VDNUM(3), .ADDR_W(24)) dut (
    .clk_sys (clk),
    .reset   (rst),
    .bus     (bus)
  );

  int errors = 0;
  int checks = 0;

  // Background memory content; lba 5 holds the i^0x5A read pattern
  function automatic logic [7:0] bg(input int a);
    if ((a >> 9) == 5) return 8'(a) ^ 8'h5A;
    return 8'(a * 7 + 3);
  endfunction

  // Core buffer content per drive; drive 1 holds 255-i
  function automatic logic [7:0] buf_val(input int d, input logic [8:0] a);
    if (d == 1) return 8'(255 - int'(a));
    return 8'(a) ^ 8'(d * 8'h11);
  endfunction

  // Backing memory model: 4 KiB, one-cycle read latency
  logic [7:0] mem [4096];
  always @(posedge clk) begin
    if (mem_init) begin
      for (int i = 0; i < 4096; i++) mem[i] <= bg(i);
      bus.mem_dout <= 8'h00;
    end else begin
      if (bus.mem_rd) bus.mem_dout <= mem[bus.mem_addr[11:0]];
      if (bus.mem_wr) mem[bus.mem_addr[11:0]] <= bus.mem_din;
    end
  end

  // Core buffers: data follows sd_buff_addr by one cycle
  always @(posedge clk) begin
    for (int d = 0; d < 3; d++) bus.sd_buff_din[d] <= buf_val(d, bus.sd_buff_addr);
  end

  // Output monitor, sampled on the falling edge
  int         cyc = 0;
  int         multi_ack = 0;
  int         ack_hi [3] = '{0, 0, 0};
  int         run    [3] = '{0, 0, 0};
  int         ack_len[3] = '{0, 0, 0};
  int         ack_rise[3] = '{0, 0, 0};
  int         ack_fall[3] = '{0, 0, 0};
  logic [2:0] prev_ack = 3'b000;
  int         rd_n = 0;
  int         mem_rd_n = 0;
  int         mem_wr_n = 0;
  logic [8:0] addr_log [4096];
  logic [7:0] data_log [4096];
  int         cyc_log  [4096];

  always @(negedge clk) begin
    cyc++;
    if ($countones(bus.sd_ack) > 1) multi_ack++;
    for (int d = 0; d < 3; d++) begin
      if (bus.sd_ack[d] === 1'b1) begin
        ack_hi[d]++;
        run[d]++;
        if (!prev_ack[d]) ack_rise[d] = cyc;
      end else if (prev_ack[d]) begin
        ack_len[d]  = run[d];
        run[d]      = 0;
        ack_fall[d] = cyc;
      end
    end
    prev_ack = bus.sd_ack;
    if (bus.sd_buff_wr === 1'b1) begin
      if (rd_n < 4096) begin
        addr_log[rd_n] = bus.sd_buff_addr;
        data_log[rd_n] = bus.sd_buff_dout;
        cyc_log[rd_n]  = cyc;
      end
      rd_n++;
    end
    if (bus.mem_rd === 1'b1) mem_rd_n++;
    if (bus.mem_wr === 1'b1) mem_wr_n++;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_ack(input int d, input int max);
    int n = 0;
    while (bus.sd_ack[d] !== 1'b1 && n < max) begin
      @(negedge clk);
      n++;
    end
    #1;
    check("ack_seen", 32'(bus.sd_ack[d]), 32'd1);
  endtask

  task automatic wait_idle(input int max);
    int n = 0;
    while (bus.busy !== 1'b0 && n < max) begin
      @(negedge clk);
      n++;
    end
    #1;
    check("idle_seen", 32'(bus.busy), 32'd0);
  endtask

  int b, bad, mr, mw, h0, h2;

  initial begin
    rst         = 1'b1;
    mem_init    = 1'b1;
    bus.sd_rd    = '0;
    bus.sd_wr    = '0;
    bus.drive_ro = '0;
    for (int d = 0; d < 3; d++) bus.sd_lba[d] = 32'd0;
    repeat (3) @(negedge clk);
    mem_init = 1'b0;

    // Reset state
    check("rst_ack", 32'(bus.sd_ack), 32'd0);
    check("rst_strobes", {28'd0, bus.sd_buff_wr, bus.mem_rd, bus.mem_wr, bus.busy}, 32'd0);
    check("rst_buff", {15'd0, bus.sd_buff_addr, bus.sd_buff_dout}, 32'd0);
    check("rst_mem", {bus.mem_addr, bus.mem_din}, 32'd0);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    check("idle_no_req", 32'(bus.busy), 32'd0);

    // Read drive 0, lba 5
    b = rd_n; mr = mem_rd_n; mw = mem_wr_n;
    bus.sd_lba[0] = 32'd5;
    bus.sd_rd[0]  = 1'b1;
    wait_ack(0, 10);
    bus.sd_rd[0]  = 1'b0;
    bus.sd_lba[0] = 32'd7;   // must be ignored mid-transfer
    wait_idle(1100);
    check("rd_count", rd_n - b, 512);
    bad = 0;
    for (int i = 0; i < 512; i++)
      if (addr_log[b+i] !== 9'(i) || data_log[b+i] !== (8'(i) ^ 8'h5A)) bad++;
    check("rd_data", bad, 0);
    check("rd_first_lat", cyc_log[b] - ack_rise[0], 2);
    check("rd_last_lat", cyc_log[b+511] - ack_rise[0], 1024);
    check("rd_ack_len", ack_len[0], 1025);
    check("rd_mem_rd", mem_rd_n - mr, 512);
    check("rd_mem_wr", mem_wr_n - mw, 0);
    check("idle_buff_addr", 32'(bus.sd_buff_addr), 32'd511);
    check("idle_mem_addr", 32'(bus.mem_addr), 32'h0BFF);
    check("idle_strobes", {29'd0, bus.sd_buff_wr, bus.mem_rd, bus.mem_wr}, 32'd0);

    // Write drive 1, lba 3
    mw = mem_wr_n; h0 = ack_hi[0]; h2 = ack_hi[2];
    bus.sd_lba[1] = 32'd3;
    bus.sd_wr[1]  = 1'b1;
    wait_ack(1, 10);
    bus.sd_wr[1]  = 1'b0;
    wait_idle(1100);
    bad = 0;
    for (int i = 0; i < 512; i++)
      if (mem[12'h600 + i] !== 8'(255 - i)) bad++;
    check("wr_data", bad, 0);
    check("wr_mem_wr", mem_wr_n - mw, 512);
    check("wr_ack_len", ack_len[1], 1025);
    check("wr_other_ack", (ack_hi[0] - h0) + (ack_hi[2] - h2), 0);

    // Simultaneous requests on drives 2 and 0
    b = rd_n;
    bus.sd_lba[0] = 32'd1;
    bus.sd_lba[2] = 32'd2;
    bus.sd_rd[2]  = 1'b1;
    bus.sd_rd[0]  = 1'b1;
    wait_ack(0, 10);
    check("prio_not2", 32'(bus.sd_ack[2]), 32'd0);
    bus.sd_rd[0] = 1'b0;
    wait_ack(2, 1100);
    bus.sd_rd[2] = 1'b0;
    wait_idle(1100);
    check("prio_gap", ack_rise[2] - ack_fall[0], 1);
    check("prio_ack2_len", ack_len[2], 1025);
    check("prio_count", rd_n - b, 1024);

    // Write-protected drive 1, lba 4
    mw = mem_wr_n;
    bus.drive_ro[1] = 1'b1;
    bus.sd_lba[1]   = 32'd4;
    bus.sd_wr[1]    = 1'b1;
    wait_ack(1, 10);
    bus.sd_wr[1]    = 1'b0;
    wait_idle(1100);
    bus.drive_ro[1] = 1'b0;
    check("ro_ack_len", ack_len[1], 1025);
    check("ro_mem_wr", mem_wr_n - mw, 0);
    bad = 0;
    for (int i = 0; i < 512; i++)
      if (mem[12'h800 + i] !== bg(12'h800 + i)) bad++;
    check("ro_mem_kept", bad, 0);

    // Out-of-range lba 0x8000: read zeros, write discarded
    b = rd_n; mr = mem_rd_n; mw = mem_wr_n;
    bus.sd_lba[0] = 32'h8000;
    bus.sd_rd[0]  = 1'b1;
    wait_ack(0, 10);
    bus.sd_rd[0]  = 1'b0;
    wait_idle(1100);
    check("oor_count", rd_n - b, 512);
    bad = 0;
    for (int i = 0; i < 512; i++)
      if (addr_log[b+i] !== 9'(i) || data_log[b+i] !== 8'h00) bad++;
    check("oor_rd_data", bad, 0);
    check("oor_mem_rd", mem_rd_n - mr, 0);
    bus.sd_wr[0] = 1'b1;
    wait_ack(0, 10);
    bus.sd_wr[0] = 1'b0;
    wait_idle(1100);
    check("oor_ack_len", ack_len[0], 1025);
    check("oor_mem_wr", mem_wr_n - mw, 0);
    bad = 0;
    for (int i = 0; i < 512; i++)
      if (mem[i] !== bg(i)) bad++;
    check("oor_mem_kept", bad, 0);

    // Asynchronous reset during read byte 100, then restart
    b = rd_n;
    bus.sd_lba[0] = 32'd5;
    bus.sd_rd[0]  = 1'b1;
    wait_ack(0, 10);
    repeat (200) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check("arst_ack", 32'(bus.sd_ack), 32'd0);
    check("arst_strobes", {28'd0, bus.sd_buff_wr, bus.mem_rd, bus.mem_wr, bus.busy}, 32'd0);
    check("arst_buff", {15'd0, bus.sd_buff_addr, bus.sd_buff_dout}, 32'd0);
    check("arst_mem", {bus.mem_addr, bus.mem_din}, 32'd0);
    check("arst_partial", rd_n - b, 100);
    repeat (2) @(negedge clk);
    check("arst_no_strobe", rd_n - b, 100);
    rst = 1'b0;
    b = rd_n;
    wait_ack(0, 10);
    bus.sd_rd[0] = 1'b0;
    wait_idle(1100);
    check("restart_count", rd_n - b, 512);
    check("restart_first_addr", 32'(addr_log[b]), 32'd0);
    bad = 0;
    for (int i = 0; i < 512; i++)
      if (addr_log[b+i] !== 9'(i) || data_log[b+i] !== (8'(i) ^ 8'h5A)) bad++;
    check("restart_data", bad, 0);
    check("restart_ack_len", ack_len[0], 1025);

    check("one_hot_ack", multi_ack, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
